spi_reg_file: RTL and testbench

//  Register-access layer directly downstream of spi_slave, on clk_core. Turns the SPI byte

---
 rtl/spi_reg_file.sv | 137 +++++++++++++
 tb/tb_spi_reg_file.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_file.sv
// spi_reg_file: register-access layer downstream of spi_slave, on clk_core.
// Frame: byte0 = {rw, addr[6:0]} (rw=1 write, rw=0 read), then data bytes.
// Ports:
//   clk_core          system clock
//   reset_n           asynchronous active-low reset
//   transaction_begin 1-cycle pulse when SS asserts; starts a new frame
//   rx_byte_available level from spi_slave; rising edge marks a new rx_byte
//   rx_byte           received byte, stable while rx_byte_available=1
//   tx_byte           next byte for spi_slave to shift out
//   bootloader_force  reg 0x01 bit0
//   scratch           reg 0x02 contents
// Optional feature: define SPI_REG_BURST_EN to auto-increment addr on each data byte.
// Without it, addr is held for the whole frame.
module spi_reg_file #(
  parameter logic [7:0] FPGA_VER    = 8'hC2,
  parameter logic [7:0] SCRATCH_RST = 8'h00
) (
  input  logic       clk_core,
  input  logic       reset_n,
  input  logic       transaction_begin,
  input  logic       rx_byte_available,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic       bootloader_force,
  output logic [7:0] scratch
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e     state_q, state_d;
  logic [1:0] hist_q;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic       boot_q, boot_d;
  logic [7:0] scratch_q, scratch_d;
  logic [7:0] err_q, err_d;
  logic [7:0] txn_q, txn_d;

  logic       rx_edge;
  logic [6:0] addr_next;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  // hist_q[0] is the newest sample of rx_byte_available.
  assign rx_edge = (hist_q == 2'b01);

`ifdef SPI_REG_BURST_EN
  assign addr_next = addr_q + 7'd1;
`else
  assign addr_next = addr_q;
`endif

  // In ADDR the read address comes straight from the incoming byte; in DATA it is
  // the address the current byte moves us to.
  assign rd_addr = (state_q == StAddr) ? rx_byte[6:0] : addr_next;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      7'h00:   rd_data = FPGA_VER;
      7'h01:   rd_data = {7'b0, boot_q};
      7'h02:   rd_data = scratch_q;
      7'h03:   rd_data = err_q;
      7'h04:   rd_data = txn_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    boot_d    = boot_q;
    scratch_d = scratch_q;
    err_d     = err_q;
    txn_d     = txn_q;
    // A new frame overrides any byte arriving in the same cycle.
    if (transaction_begin) begin
      state_d = StAddr;
      tx_d    = 8'h00;
      txn_d   = txn_q + 8'd1;
    end else if (rx_edge) begin
      unique case (state_q)
        StAddr: begin
          rw_d    = rx_byte[7];
          addr_d  = rx_byte[6:0];
          state_d = StData;
          if (!rx_byte[7]) tx_d = rd_data;
        end
        StData: begin
          if (rw_q) begin
            case (addr_q)
              7'h01:   boot_d    = rx_byte[0];
              7'h02:   scratch_d = rx_byte;
              default: if (err_q != 8'hFF) err_d = err_q + 8'd1;
            endcase
          end else begin
            tx_d = rd_data;
          end
          addr_d = addr_next;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      hist_q    <= 2'b00;
      tx_q      <= 8'h00;
      rw_q      <= 1'b0;
      addr_q    <= 7'h00;
      boot_q    <= 1'b0;
      scratch_q <= SCRATCH_RST;
      err_q     <= 8'h00;
      txn_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      hist_q    <= {hist_q[0], rx_byte_available};
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      boot_q    <= boot_d;
      scratch_q <= scratch_d;
      err_q     <= err_d;
      txn_q     <= txn_d;
    end
  end

  assign tx_byte          = tx_q;
  assign bootloader_force = boot_q;
  assign scratch          = scratch_q;

endmodule

// File: tb/tb_spi_reg_file.sv
// tb_spi_reg_file: directed bench for spi_reg_file with hand-computed expectations.
// Works with or without SPI_REG_BURST_EN defined.
module tb_spi_reg_file;

  logic       clk_core = 1'b0;
  logic       reset_n = 1'b0;
  logic       transaction_begin = 1'b0;
  logic       rx_byte_available = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       bootloader_force;
  logic [7:0] scratch;

  int errors = 0;
  int checks = 0;

  logic [7:0] t0, t1;

`ifdef SPI_REG_BURST_EN
  localparam logic [7:0] ExpT3Scratch = 8'hA5;
  localparam logic [7:0] ExpT3Err     = 8'h01;
  localparam logic [7:0] ExpT3Rd1     = 8'h01;
  localparam logic [7:0] ExpT5Rd1     = 8'hC2;
`else
  localparam logic [7:0] ExpT3Scratch = 8'h11;
  localparam logic [7:0] ExpT3Err     = 8'h00;
  localparam logic [7:0] ExpT3Rd1     = 8'h11;
  localparam logic [7:0] ExpT5Rd1     = 8'h00;
`endif

  spi_reg_file dut (
    .clk_core          (clk_core),
    .reset_n           (reset_n),
    .transaction_begin (transaction_begin),
    .rx_byte_available (rx_byte_available),
    .rx_byte           (rx_byte),
    .tx_byte           (tx_byte),
    .bootloader_force  (bootloader_force),
    .scratch           (scratch)
  );

  always #10 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_frame();
    @(posedge clk_core);
    #1 transaction_begin = 1'b1;
    @(posedge clk_core);
    #1 transaction_begin = 1'b0;
  endtask

  // Presents one byte and returns tx_byte once it has had time to update.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] tx);
    @(posedge clk_core);
    #1 rx_byte = b;
    rx_byte_available = 1'b1;
    repeat (3) @(posedge clk_core);
    #1 tx = tx_byte;
    rx_byte_available = 1'b0;
    repeat (2) @(posedge clk_core);
  endtask

  task automatic do_reset();
    @(posedge clk_core);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk_core);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    // T1: reset values and version read
    repeat (2) @(posedge clk_core);
    #1;
    check("t1_rst_tx", tx_byte, 8'h00);
    check("t1_rst_boot", {7'b0, bootloader_force}, 8'h00);
    check("t1_rst_scratch", scratch, 8'h00);
    reset_n = 1'b1;
    begin_frame();
    check("t1_begin_tx", tx_byte, 8'h00);
    send_byte(8'h00, t0);
    check("t1_version", t0, 8'hC2);

    // T2: boot bit write and readback
    begin_frame();
    send_byte(8'h81, t0);
    send_byte(8'h01, t1);
    check("t2_boot", {7'b0, bootloader_force}, 8'h01);
    begin_frame();
    send_byte(8'h01, t0);
    check("t2_boot_rd", t0, 8'h01);

    // T3: burst write, error count, burst read
    begin_frame();
    send_byte(8'h82, t0);
    send_byte(8'hA5, t0);
    send_byte(8'h11, t0);
    check("t3_scratch", scratch, ExpT3Scratch);
    begin_frame();
    send_byte(8'h03, t0);
    check("t3_err_cnt", t0, ExpT3Err);
    begin_frame();
    send_byte(8'h02, t0);
    send_byte(8'h00, t1);
    check("t3_burst_rd0", t0, ExpT3Scratch);
    check("t3_burst_rd1", t1, ExpT3Rd1);

    // T4: err_cnt saturation and txn_cnt wrap; 300 frames counted from reset
    do_reset();
    for (int i = 0; i < 257; i++) begin
      begin_frame();
      send_byte(8'h80, t0);
      send_byte(8'h55, t0);
    end
    begin_frame();                      // frame 258
    send_byte(8'h03, t0);
    check("t4_err_sat", t0, 8'hFF);
    check("t4_scratch", scratch, 8'h00);
    for (int i = 0; i < 41; i++) begin_frame();  // frames 259..299
    begin_frame();                      // frame 300
    send_byte(8'h04, t0);
    check("t4_txn_cnt", t0, 8'h2C);

    // T5: read burst across the 0x7F -> 0x00 wrap
    begin_frame();
    send_byte(8'h7F, t0);
    send_byte(8'h00, t1);
    check("t5_rd_7f", t0, 8'h00);
    check("t5_rd_wrap", t1, ExpT5Rd1);

    // T6: begin colliding with rx_edge drops the byte
    begin_frame();
    send_byte(8'h82, t0);
    send_byte(8'h3C, t0);
    begin_frame();
    send_byte(8'h00, t0);
    check("t6_pre_rd", t0, 8'hC2);
    @(posedge clk_core);
    #1 rx_byte = 8'h00;
    rx_byte_available = 1'b1;
    @(posedge clk_core);                // rx_edge is high during the next cycle
    #1 transaction_begin = 1'b1;
    @(posedge clk_core);
    #1 transaction_begin = 1'b0;
    check("t6_collide_tx", tx_byte, 8'h00);
    rx_byte_available = 1'b0;
    repeat (2) @(posedge clk_core);
    send_byte(8'h02, t0);
    check("t6_addr_after", t0, 8'h3C);

    // T6: asynchronous reset mid-frame
    begin_frame();
    send_byte(8'h81, t0);
    send_byte(8'h01, t0);
    begin_frame();
    send_byte(8'h02, t0);
    check("t6_pre_rst_tx", t0, 8'h3C);
    check("t6_pre_rst_boot", {7'b0, bootloader_force}, 8'h01);
    @(posedge clk_core);
    #5 reset_n = 1'b0;
    #1;
    check("t6_rst_tx", tx_byte, 8'h00);
    check("t6_rst_boot", {7'b0, bootloader_force}, 8'h00);
    check("t6_rst_scratch", scratch, 8'h00);
    @(posedge clk_core);
    #1 reset_n = 1'b1;
    send_byte(8'h00, t0);               // no begin: IDLE ignores it
    check("t6_idle_ignore", t0, 8'h00);
    begin_frame();
    send_byte(8'h00, t0);
    check("t6_recover", t0, 8'hC2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
